// File: rtl/cam_line_fifo.sv
// Packs RGB565 camera bytes into RGB888 words and buffers them in a first-word-fall-through FIFO.
// Define CAM_TEST_PATTERN_EN to replace camera pixels with an {x, y, 8'h80} coordinate pattern.
module cam_line_fifo #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              Cam_VSync,
   input  logic              Cam_HRef,
   input  logic              Cam_Valid,
   input  logic [7:0]        Cam_Byte,
   input  logic              Mem_Read,
   output logic [DATA_W-1:0] Mem_Data,
   output logic              FraimSync,
   output logic [ADDR_W:0]   Fifo_Level,
   input  logic              Ovf_Clr,
   output logic              Overflow,
   output logic              Underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LEVEL_FULL = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] mem [DEPTH];

   logic              vsync_q;
   logic              phase_q, phase_d;
   logic [7:0]        hiByte_q, hiByte_d;
   logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              fraim_q, fraim_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              vsyncRise;
   logic              byteEn;
   logic              pixWr;
   logic              empty;
   logic              full;
   logic              doRead;
   logic              doWrite;
   logic [DATA_W-1:0] pixData;

   function automatic logic [23:0] expandRgb(input logic [7:0] hi, input logic [7:0] lo);
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      r5 = hi[7:3];
      g6 = {hi[2:0], lo[7:5]};
      b5 = lo[4:0];
      return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
   endfunction

`ifdef CAM_TEST_PATTERN_EN
   logic       href_q;
   logic [9:0] xCnt_q, xCnt_d;
   logic [9:0] yCnt_q, yCnt_d;

   always_comb begin
      xCnt_d = xCnt_q;
      yCnt_d = yCnt_q;
      if (!Cam_HRef) begin
         xCnt_d = '0;
      end else if (pixWr) begin
         xCnt_d = xCnt_q + 10'd1;
      end
      if (vsyncRise) begin
         yCnt_d = '0;
      end else if (href_q && !Cam_HRef) begin
         yCnt_d = yCnt_q + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         href_q <= 1'b0;
         xCnt_q <= '0;
         yCnt_q <= '0;
      end else begin
         href_q <= Cam_HRef;
         xCnt_q <= xCnt_d;
         yCnt_q <= yCnt_d;
      end
   end

   assign pixData = {xCnt_q[7:0], yCnt_q[7:0], 8'h80};
`else
   assign pixData = expandRgb(hiByte_q, Cam_Byte);
`endif

   assign vsyncRise = Cam_VSync & ~vsync_q;
   assign byteEn    = Cam_Valid & Cam_HRef;
   assign pixWr     = byteEn & phase_q;
   assign empty     = (level_q == '0);
   assign full      = (level_q == LEVEL_FULL);
   assign doRead    = Mem_Read & ~empty;
   // A full FIFO still accepts a pixel when the head is popped in the same cycle.
   assign doWrite   = pixWr & (~full | Mem_Read);

   always_comb begin
      phase_d  = phase_q;
      hiByte_d = hiByte_q;
      wrPtr_d  = wrPtr_q;
      rdPtr_d  = rdPtr_q;
      level_d  = level_q;
      fraim_d  = fraim_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      if (byteEn && !phase_q) begin
         hiByte_d = Cam_Byte;
      end
      if (vsyncRise || !Cam_HRef) begin
         phase_d = 1'b0;
      end else if (Cam_Valid) begin
         phase_d = ~phase_q;
      end
      if (vsyncRise) begin
         fraim_d = ~fraim_q;
      end

      if (doWrite) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (doRead) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({doWrite, doRead})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      if (pixWr && full && !Mem_Read) begin
         ovf_d = 1'b1;
      end
      if (Mem_Read && empty) begin
         unf_d = 1'b1;
      end
      if (Ovf_Clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vsync_q  <= 1'b0;
         phase_q  <= 1'b0;
         hiByte_q <= '0;
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         level_q  <= '0;
         fraim_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         vsync_q  <= Cam_VSync;
         phase_q  <= phase_d;
         hiByte_q <= hiByte_d;
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         level_q  <= level_d;
         fraim_q  <= fraim_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage has no reset; an empty FIFO masks whatever it holds.
   always_ff @(posedge clk) begin
      if (doWrite) begin
         mem[wrPtr_q] <= pixData;
      end
   end

   assign Mem_Data   = empty ? '0 : mem[rdPtr_q];
   assign FraimSync  = fraim_q;
   assign Fifo_Level = level_q;
   assign Overflow   = ovf_q;
   assign Underflow  = unf_q;

endmodule

// File: tb/tb_cam_line_fifo.sv
// Self-checking bench for cam_line_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_cam_line_fifo;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rstn;
   logic        Cam_VSync, Cam_HRef, Cam_Valid;
   logic [7:0]  Cam_Byte;
   logic        Mem_Read;
   logic [23:0] Mem_Data;
   logic        FraimSync;
   logic [10:0] Fifo_Level;
   logic        Ovf_Clr;
   logic        Overflow, Underflow;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [23:0] mQueue[$];
   bit          mHaveHi;
   logic [7:0]  mHi;
   bit          mPrevVs, mPrevHref;
   bit          mFraim, mOvf, mUnf;
   int          mX, mY;

   cam_line_fifo #(.ADDR_W(10), .DATA_W(24)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .Cam_VSync  (Cam_VSync),
      .Cam_HRef   (Cam_HRef),
      .Cam_Valid  (Cam_Valid),
      .Cam_Byte   (Cam_Byte),
      .Mem_Read   (Mem_Read),
      .Mem_Data   (Mem_Data),
      .FraimSync  (FraimSync),
      .Fifo_Level (Fifo_Level),
      .Ovf_Clr    (Ovf_Clr),
      .Overflow   (Overflow),
      .Underflow  (Underflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // RGB565 -> RGB888 by shifting each channel up and refilling low bits from its MSBs
   function automatic logic [23:0] refExpand(input logic [7:0] hi, input logic [7:0] lo);
      int rgb, r5, g6, b5, r8, g8, b8;
      rgb = hi * 256 + lo;
      r5 = rgb / 2048;
      g6 = (rgb / 32) % 64;
      b5 = rgb % 32;
      r8 = r5 * 8 + r5 / 4;
      g8 = g6 * 4 + g6 / 16;
      b8 = b5 * 8 + b5 / 4;
      return 24'(r8 * 65536 + g8 * 256 + b8);
   endfunction

   task automatic modelReset();
      mQueue.delete();
      mHaveHi = 0; mHi = 8'h00;
      mPrevVs = 0; mPrevHref = 0;
      mFraim = 0; mOvf = 0; mUnf = 0;
      mX = 0; mY = 0;
   endtask

   task automatic modelEdge();
      bit rise, byteIn, pixel;
      int sizeBefore;
      logic [23:0] word;
      rise = Cam_VSync && !mPrevVs;
      byteIn = Cam_HRef && Cam_Valid;
      pixel = byteIn && mHaveHi;
`ifdef CAM_TEST_PATTERN_EN
      word = {8'(mX % 256), 8'(mY % 256), 8'h80};
`else
      word = refExpand(mHi, Cam_Byte);
`endif
      sizeBefore = mQueue.size();
      if (Mem_Read && sizeBefore == 0) mUnf = 1;
      if (pixel && sizeBefore == DEPTH && !Mem_Read) mOvf = 1;
      if (Ovf_Clr) begin
         mOvf = 0;
         mUnf = 0;
      end
      if (Mem_Read && sizeBefore > 0) void'(mQueue.pop_front());
      if (pixel && (sizeBefore < DEPTH || Mem_Read)) mQueue.push_back(word);
      if (byteIn && !mHaveHi) mHi = Cam_Byte;
      if (rise || !Cam_HRef) mHaveHi = 0;
      else if (Cam_Valid) mHaveHi = !mHaveHi;
      if (rise) mFraim = !mFraim;
      if (!Cam_HRef) mX = 0;
      else if (pixel) mX = (mX + 1) % 1024;
      if (rise) mY = 0;
      else if (mPrevHref && !Cam_HRef) mY = (mY + 1) % 1024;
      mPrevVs = Cam_VSync;
      mPrevHref = Cam_HRef;
   endtask

   task automatic checkAll();
      checkOutput("mem_data", Mem_Data, (mQueue.size() > 0) ? mQueue[0] : 24'h0);
      checkOutput("level", Fifo_Level, mQueue.size());
      checkOutput("overflow", Overflow, mOvf);
      checkOutput("underflow", Underflow, mUnf);
      checkOutput("fraimsync", FraimSync, mFraim);
   endtask

   // Drive one cycle of inputs at the falling edge, step the model at the rising edge, check just after.
   task automatic applyStimulus(input bit vs, input bit href, input bit valid, input logic [7:0] b,
                                input bit rd, input bit clr);
      Cam_VSync = vs; Cam_HRef = href; Cam_Valid = valid; Cam_Byte = b;
      Mem_Read = rd; Ovf_Clr = clr;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
   endtask

   task automatic pixelPair(input logic [7:0] hi, input logic [7:0] lo, input bit rdOnSecond);
      applyStimulus(0, 1, 1, hi, 0, 0);
      applyStimulus(0, 1, 1, lo, rdOnSecond, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 1100 && mQueue.size() > 0; i++) applyStimulus(0, 0, 0, 8'h00, 1, 0);
   endtask

   initial begin
      rstn = 1'b1;
      Cam_VSync = 0; Cam_HRef = 0; Cam_Valid = 0; Cam_Byte = 8'h00;
      Mem_Read = 0; Ovf_Clr = 0;
      modelReset();
      #2 rstn = 1'b0;
      #1;
      checkOutput("reset_data", Mem_Data, 24'h0);
      checkOutput("reset_level", Fifo_Level, 0);
      checkOutput("reset_fraim", FraimSync, 0);
      checkOutput("reset_ovf", Overflow, 0);
      checkOutput("reset_unf", Underflow, 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

`ifndef CAM_TEST_PATTERN_EN
      // Pure red, then green and blue
      pixelPair(8'hF8, 8'h00, 0);
      checkOutput("red_word", Mem_Data, 24'hFF0000);
      checkOutput("red_level", Fifo_Level, 1);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      pixelPair(8'h07, 8'hE0, 0);
      pixelPair(8'h00, 8'h1F, 0);
      idle();
      checkOutput("green_word", Mem_Data, 24'h00FF00);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      checkOutput("blue_word", Mem_Data, 24'h0000FF);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      checkOutput("drained_level", Fifo_Level, 0);
      checkOutput("drained_data", Mem_Data, 24'h0);
`endif

      // Fill to capacity, overflow, full write with read, clear
      for (int i = 0; i < DEPTH; i++) pixelPair(8'($urandom), 8'($urandom), 0);
      checkOutput("full_level", Fifo_Level, DEPTH);
      pixelPair(8'h12, 8'h34, 0);
      checkOutput("ovf_set", Overflow, 1);
      checkOutput("ovf_level", Fifo_Level, DEPTH);
      pixelPair(8'h56, 8'h78, 1);
      checkOutput("full_rdwr_level", Fifo_Level, DEPTH);
      applyStimulus(0, 0, 0, 8'h00, 0, 1);
      checkOutput("ovf_clr", Overflow, 0);
      drain();
      checkOutput("after_fill_level", Fifo_Level, 0);

      // Underflow, then read-while-empty with a simultaneous write
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      checkOutput("unf_set", Underflow, 1);
      checkOutput("unf_level", Fifo_Level, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 1);
      checkOutput("unf_clr", Underflow, 0);
      pixelPair(8'hA5, 8'h5A, 1);
      checkOutput("empty_rdwr_level", Fifo_Level, 1);
`ifndef CAM_TEST_PATTERN_EN
      checkOutput("empty_rdwr_data", Mem_Data, refExpand(8'hA5, 8'h5A));
`endif
      applyStimulus(0, 0, 0, 8'h00, 1, 1);

      // Frame parity across three VSync pulses
      applyStimulus(1, 0, 0, 8'h00, 0, 0);
      checkOutput("fraim_1", FraimSync, 1);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      applyStimulus(1, 0, 0, 8'h00, 0, 0);
      checkOutput("fraim_2", FraimSync, 0);
      applyStimulus(1, 0, 0, 8'h00, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      applyStimulus(1, 0, 0, 8'h00, 0, 0);
      checkOutput("fraim_3", FraimSync, 1);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);

      // A lone byte before an HRef drop must not form a pixel
      applyStimulus(0, 1, 1, 8'hFF, 0, 0);
      idle();
      checkOutput("lone_byte_level", Fifo_Level, 0);
      pixelPair(8'h11, 8'h22, 0);
      checkOutput("after_drop_level", Fifo_Level, 1);

      // Mid-frame asynchronous reset discards everything including a half pixel
      applyStimulus(0, 1, 1, 8'h33, 0, 0);
      Cam_HRef = 0; Cam_Valid = 0;
      #2 rstn = 1'b0;
      #1;
      modelReset();
      checkOutput("midreset_level", Fifo_Level, 0);
      checkOutput("midreset_data", Mem_Data, 24'h0);
      checkOutput("midreset_fraim", FraimSync, 0);
      @(negedge clk);
      rstn = 1'b1;

`ifdef CAM_TEST_PATTERN_EN
      // Line 3, pixel 5 of a fresh frame carries its coordinates
      applyStimulus(1, 0, 0, 8'h00, 0, 0);
      for (int ln = 0; ln < 3; ln++) begin
         applyStimulus(0, 1, 0, 8'h00, 0, 0);
         idle();
      end
      for (int p = 0; p < 6; p++) pixelPair(8'h00, 8'h00, p > 0);
      checkOutput("pattern_l3_p5", Mem_Data, 24'h050380);
      idle();
      drain();
`endif

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 15) != 0,
                       $urandom_range(0, 3) != 0,
                       8'($urandom),
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 49) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
